vga_pixel_stream: RTL and testbench

Pixel-stream buffer that sits directly upstream of the VGA colour outputs. It accepts 3-bit RGB pixels from a producer over a valid/ready handshake and buffers them in a FIFO. Driven by the hsync/vsync blanking signals and a pixel-enable tick, it emits exactly one pixel per visible pixel slot. It aligns each frame to a start-of-frame marker and recovers cleanly from underrun or misalignment by waiting for the next vertical blank.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_stream_fifo.sv | 68 ++++++
 rtl/vga_pixel_stream.sv | 168 ++++++++++++++++
 tb/tb_vga_pixel_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel-stream buffer: FSM states and the FIFO entry.
// The optional underrun counter is enabled with VGA_STREAM_UNDERRUN_CNT_EN.
package vga_pkg;

  localparam int RGB_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  typedef struct packed {
    logic             sof;
    logic [RGB_W-1:0] rgb;
  } pix_entry_t;

endpackage

// File: rtl/vga_stream_fifo.sv
// Single-clock pixel FIFO with a separate occupancy counter and a one-cycle flush.
// Head is read combinationally so the caller can inspect sof on the popping tick.
module vga_stream_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [RGB_W:0]   i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [RGB_W:0]   o_head,
  output logic [LVL_W-1:0] o_level
);

  pix_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign do_push = i_push && (level_q != LVL_W'(DEPTH));
  assign do_pop  = i_pop && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never cleared; flush only rewinds the pointers.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_level = level_q;

endmodule

// File: rtl/vga_pixel_stream.sv
// Buffers producer pixels and emits one per visible VGA pixel slot, frame-aligned on sof.
// Define VGA_STREAM_UNDERRUN_CNT_EN to add the saturating o_underrun_cnt output.
module vga_pixel_stream
  import vga_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_en,
  input  logic             i_hblank,
  input  logic             i_vblank,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [RGB_W-1:0] i_rgb,
  output logic             o_ready,
  output logic             o_red,
  output logic             o_grn,
  output logic             o_blu,
  output logic [LVL_W-1:0] o_level,
  output logic             o_underrun,
  output logic             o_sync_err
`ifdef VGA_STREAM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      o_underrun_cnt
`endif
);

  state_e           state_q, state_d;
  logic             vblank_q;
  logic             first_q, first_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             underrun_q, underrun_d;
  logic             sync_err_q, sync_err_d;
  logic [LVL_W-1:0] level;
  logic [RGB_W:0]   head_raw;
  pix_entry_t       head;
  logic             vblank_rise, vblank_fall, vis_tick;
  logic             fifo_empty, fifo_full;
  logic             accept, push, pop, flush, underrun_evt;

  assign vblank_rise = i_vblank && !vblank_q;
  assign vblank_fall = !i_vblank && vblank_q;
  assign vis_tick    = i_pix_en && !i_hblank && !i_vblank;
  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == LVL_W'(DEPTH));
  assign head        = head_raw;

  assign o_ready = (state_q != ST_IDLE) && !fifo_full;
  assign accept  = i_valid && o_ready;
  // Until an sof pixel lands, pre-frame junk is handshaken but dropped.
  assign push    = accept && !((state_q == ST_PREFILL) && fifo_empty && !i_sof);
  assign pop     = vis_tick && (state_q == ST_ACTIVE) && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    flush        = 1'b0;
    underrun_evt = 1'b0;
    sync_err_d   = sync_err_q;
    case (state_q)
      ST_IDLE: begin
        if (vblank_rise) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (vblank_fall) begin
          if (level >= LVL_W'(PREFILL)) begin
            state_d = ST_ACTIVE;
            first_d = 1'b1;
          end else begin
            underrun_evt = 1'b1;
            flush        = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_ACTIVE: begin
        if (vblank_rise) begin
          // Leftover pixels mean the producer wrote more than one frame's worth.
          if (!fifo_empty) begin
            sync_err_d = 1'b1;
            flush      = 1'b1;
          end
          state_d = ST_PREFILL;
        end else if (vis_tick) begin
          if (fifo_empty) begin
            underrun_evt = 1'b1;
            flush        = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            first_d = 1'b0;
            if (head.sof && !first_q) begin
              sync_err_d = 1'b1;
              flush      = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    underrun_d = underrun_q || underrun_evt;
  end

  always_comb begin
    rgb_d = rgb_q;
    if (state_q != ST_ACTIVE) begin
      rgb_d = '0;
    end else if (i_pix_en) begin
      rgb_d = pop ? head.rgb : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      vblank_q   <= 1'b1;
      first_q    <= 1'b0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblank_q   <= i_vblank;
      first_q    <= first_d;
      rgb_q      <= rgb_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  vga_stream_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  ({i_sof, i_rgb}),
    .i_pop   (pop),
    .i_flush (flush),
    .o_head  (head_raw),
    .o_level (level)
  );

`ifdef VGA_STREAM_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      urun_cnt_q <= '0;
    end else if (underrun_evt && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_q <= urun_cnt_q + 16'd1;
    end
  end

  assign o_underrun_cnt = urun_cnt_q;
`endif

  assign o_red      = rgb_q[2];
  assign o_grn      = rgb_q[1];
  assign o_blu      = rgb_q[0];
  assign o_level    = level;
  assign o_underrun = underrun_q;
  assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Frame-level bench for vga_pixel_stream on a 4x2 raster (4 vblank lines, 2 hblank px per line).
// Checks against a queue-based model every cycle, plus literal per-frame pixel lists.
module tb_vga_pixel_stream;

  localparam int DEPTH = 16;
  localparam int PREF  = 8;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_pix_en = 1'b0, i_hblank = 1'b1, i_vblank = 1'b1;
  logic       i_valid = 1'b0, i_sof = 1'b0;
  logic [2:0] i_rgb = 3'd0;
  logic       o_ready, o_red, o_grn, o_blu, o_underrun, o_sync_err;
  logic [4:0] o_level;
`ifdef VGA_STREAM_UNDERRUN_CNT_EN
  logic [15:0] o_underrun_cnt;
`endif

  vga_pixel_stream #(.DEPTH(DEPTH), .PREFILL(PREF)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_pix_en   (i_pix_en),
    .i_hblank   (i_hblank),
    .i_vblank   (i_vblank),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .i_rgb      (i_rgb),
    .o_ready    (o_ready),
    .o_red      (o_red),
    .o_grn      (o_grn),
    .o_blu      (o_blu),
    .o_level    (o_level),
    .o_underrun (o_underrun),
    .o_sync_err (o_sync_err)
`ifdef VGA_STREAM_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt (o_underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Reference model: mode 0 = waiting for vblank, 1 = filling, 2 = streaming.
  int         m_mode;
  bit [3:0]   m_q[$];
  bit         m_first, m_urun, m_serr, m_vbp, prev_vis;
  bit [2:0]   m_rgb;
  int         m_ucnt;
  bit [2:0]   shown[$];

  task automatic model_step();
    bit vrise, vfall, vis, acc, flush, popped;
    bit [3:0] e;
    int nxt;
    vrise  = i_vblank && !m_vbp;
    vfall  = !i_vblank && m_vbp;
    vis    = i_pix_en && !i_hblank && !i_vblank;
    acc    = i_valid && (m_mode != 0) && (m_q.size() < DEPTH);
    flush  = 0;
    popped = 0;
    e      = 4'd0;
    nxt    = m_mode;
    if (m_mode == 0) begin
      if (vrise) nxt = 1;
    end else if (m_mode == 1) begin
      if (vfall) begin
        if (m_q.size() >= PREF) begin
          nxt = 2;
          m_first = 1;
        end else begin
          m_urun = 1;
          if (m_ucnt < 65535) m_ucnt++;
          flush = 1;
          nxt = 0;
        end
      end
    end else begin
      if (vrise) begin
        if (m_q.size() != 0) begin
          m_serr = 1;
          flush = 1;
        end
        nxt = 1;
      end else if (vis) begin
        if (m_q.size() == 0) begin
          m_urun = 1;
          if (m_ucnt < 65535) m_ucnt++;
          flush = 1;
          nxt = 0;
        end else begin
          e = m_q.pop_front();
          popped = 1;
          if (e[3] && !m_first) begin
            m_serr = 1;
            flush = 1;
            nxt = 0;
          end
          m_first = 0;
        end
      end
    end
    if (m_mode != 2) m_rgb = 3'd0;
    else if (i_pix_en) m_rgb = popped ? e[2:0] : 3'd0;
    if (flush) m_q.delete();
    else if (acc && !(m_mode == 1 && m_q.size() == 0 && !i_sof)) m_q.push_back({i_sof, i_rgb});
    m_mode   = nxt;
    m_vbp    = i_vblank;
    prev_vis = vis;
  endtask

  always @(negedge clk) begin
    if (!i_rst_n) begin
      m_mode = 0; m_q.delete(); m_first = 0; m_rgb = 3'd0;
      m_urun = 0; m_serr = 0; m_ucnt = 0; m_vbp = 1; prev_vis = 0;
    end else if (prev_vis) begin
      shown.push_back({o_red, o_grn, o_blu});
    end
    check("ready", o_ready, (m_mode != 0) && (m_q.size() < DEPTH));
    check("rgb", {o_red, o_grn, o_blu}, m_rgb);
    check("level", o_level, m_q.size());
    check("underrun", o_underrun, m_urun);
    check("sync_err", o_sync_err, m_serr);
`ifdef VGA_STREAM_UNDERRUN_CNT_EN
    check("underrun_cnt", o_underrun_cnt, m_ucnt);
`endif
    if (i_rst_n) model_step();
  end

  // Raster and producer, advanced one clock per step().
  int       pos = 0, line = 0, frame_lines = 6;
  bit [3:0] prod_q[$];

  task automatic drive_inputs();
    i_vblank = (line < 4);
    i_hblank = (pos >= 8);
    i_pix_en = (pos % 2 == 1);
    if (prod_q.size() > 0) begin
      i_valid = 1'b1;
      {i_sof, i_rgb} = prod_q[0];
    end else begin
      i_valid = 1'b0;
      i_sof = 1'b0;
      i_rgb = 3'd0;
    end
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = i_valid && o_ready;
    @(posedge clk);
    #1;
    if (acc && prod_q.size() > 0) void'(prod_q.pop_front());
    pos++;
    if (pos == 12) begin
      pos = 0;
      line++;
      if (line == frame_lines) begin
        line = 0;
        frame_lines = 6;
      end
    end
    drive_inputs();
  endtask

  task automatic to_frame_start();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(pos == 0 && line == 0) && n < 200);
  endtask

  // Pixels and expected colours are hex nibble lists, first item in the most significant nibble.
  task automatic frame(input string name, input int vis, input int npix, input bit [63:0] pix,
                       input int nexp, input bit [63:0] exp);
    bit [63:0] sh;
    frame_lines = 4 + vis;
    shown.delete();
    repeat (3) step();
    for (int i = 0; i < npix; i++) begin
      sh = pix >> (4 * (npix - 1 - i));
      prod_q.push_back(sh[3:0]);
    end
    to_frame_start();
    check({name, "_drained"}, prod_q.size(), 0);
    prod_q.delete();
    check({name, "_count"}, shown.size(), nexp);
    for (int i = 0; i < nexp; i++) begin
      sh = exp >> (4 * (nexp - 1 - i));
      if (i < shown.size()) check($sformatf("%s_px%0d", name, i), shown[i], sh[2:0]);
    end
    $display("frame %s: pushed %0d, displayed %0d pixels", name, npix, shown.size());
  endtask

  initial begin
    drive_inputs();
    repeat (4) step();
    check("rst_ready", o_ready, 0);
    check("rst_rgb", {o_red, o_grn, o_blu}, 0);
    check("rst_level", o_level, 0);
    check("rst_underrun", o_underrun, 0);
    check("rst_sync_err", o_sync_err, 0);
    i_rst_n = 1'b1;
    to_frame_start();

    frame("nominal", 2, 8, 64'h92345670, 8, 64'h12345670);
    check("nominal_flags", {o_underrun, o_sync_err}, 0);
    frame("junk", 2, 11, 64'h777D3612475, 8, 64'h53612475);
    frame("shortfall", 2, 5, 64'h92345, 8, 64'h0);
    check("shortfall_underrun", o_underrun, 1);
    frame("recovery", 2, 8, 64'hE5432176, 8, 64'h65432176);
    frame("midframe_underrun", 3, 8, 64'hA4613572, 12, 64'h246135720000);
    check("underrun_ready_low", o_ready, 0);
    check("sync_err_before_overrun", o_sync_err, 0);
    frame("overrun", 2, 9, 64'h923456712, 8, 64'h12345671);
    step();
    check("overrun_sync_err", o_sync_err, 1);
    check("overrun_flushed", o_level, 0);
    frame("second_sof", 2, 8, 64'h92348567, 8, 64'h12340000);
    check("second_sof_level", o_level, 0);
    frame("final_good", 2, 8, 64'hF6543210, 8, 64'h76543210);
`ifdef VGA_STREAM_UNDERRUN_CNT_EN
    check("underrun_cnt_final", o_underrun_cnt, 2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
